// File: rtl/mips_pkg.sv
// Shared MIPS core types and constants: default datapath widths, the
// write-back entry carried from MEM to WB, and the hard-wired zero register.
// No ports (package).
package mips_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_REG_AW = 3;

  // Register 0 always reads as zero, so writes to it must never reach the RF.
  localparam int REG_ZERO = 0;

  // Write-back entry at default widths; modules with other widths build the
  // same shape locally from their own parameters.
  typedef struct packed {
    logic [DEF_DATA_W-1:0] wb_data;
    logic [DEF_REG_AW-1:0] write_reg;
    logic                  reg_write;
  } wb_entry_t;

endpackage

// File: rtl/wb_skid_buf.sv
// Generic 2-entry valid/ready skid buffer (main + skid register), order preserving.
// Latency: 1 negedge from accept to out_valid when main is empty or draining.
// Backpressure: in_ready = !skid_valid (registered); flush empties both entries.
// Ports: clk, rst (async high), flush; in_valid/in_ready/in_entry upstream;
//        out_valid/out_ready/out_entry downstream (driven from main register only).
module wb_skid_buf
  import mips_pkg::*;
#(
  parameter type entry_t = wb_entry_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   flush,
  input  logic   in_valid,
  output logic   in_ready,
  input  entry_t in_entry,
  output logic   out_valid,
  input  logic   out_ready,
  output entry_t out_entry
);

  logic   main_vld_q, main_vld_d;
  logic   skid_vld_q, skid_vld_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   accept;
  logic   emit;

  assign in_ready  = !skid_vld_q;
  assign accept    = in_valid & in_ready;
  assign emit      = main_vld_q & out_ready;
  assign out_valid = main_vld_q;
  assign out_entry = main_q;

  always_comb begin
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    main_d     = main_q;
    skid_d     = skid_q;
    if (flush) begin
      // Squash wins over everything; an emit this cycle was already seen by the RF.
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (skid_vld_q) begin
      // Full: the older skid entry moves up before anything new can enter.
      if (emit) begin
        main_d     = skid_q;
        skid_vld_d = 1'b0;
      end
    end else if (main_vld_q) begin
      if (accept && emit) begin
        main_d = in_entry;
      end else if (accept) begin
        skid_d     = in_entry;
        skid_vld_d = 1'b1;
      end else if (emit) begin
        main_vld_d = 1'b0;
      end
    end else if (accept) begin
      main_d     = in_entry;
      main_vld_d = 1'b1;
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Elastic MEM->WB register: write-back mux on entry, 2-entry skid buffer, reg-0 guard,
// forwarding tap and saturating stall counter. Latency: 1 negedge accept->out_valid.
// Backpressure: in_ready drops when both entries are held; flush squashes held entries.
// Ports: clk, rst, flush; in_* from MEM (valid/ready + mux inputs + dest reg);
//        out_* to register file; fwd_* tap for the EX hazard unit; stall_cnt.
module mem_wb_stage
  import mips_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int REG_AW     = DEF_REG_AW,
  parameter bit ZERO_GUARD = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_mem_to_reg,
  input  logic [DATA_W-1:0] in_read_data,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [REG_AW-1:0] in_write_reg,
  input  logic              in_reg_write,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_wb_data,
  output logic [REG_AW-1:0] out_write_reg,
  output logic              out_reg_write,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_reg,
  output logic [DATA_W-1:0] fwd_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Same shape as wb_entry_t, sized by this instance's parameters.
  typedef struct packed {
    logic [DATA_W-1:0] wb_data;
    logic [REG_AW-1:0] write_reg;
    logic              reg_write;
  } entry_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  entry_t           in_entry;
  entry_t           out_entry;
  logic             is_reg0;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Only the selected value is captured; mux inputs are not stored.
  always_comb begin
    in_entry           = '0;
    in_entry.wb_data   = in_mem_to_reg ? in_read_data : in_alu_result;
    in_entry.write_reg = in_write_reg;
    in_entry.reg_write = in_reg_write;
  end

  wb_skid_buf #(
    .entry_t (entry_t)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_entry  (in_entry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_entry (out_entry)
  );

  assign out_wb_data   = out_entry.wb_data;
  assign out_write_reg = out_entry.write_reg;
  assign is_reg0       = (out_entry.write_reg == REG_AW'(REG_ZERO));
  // Reg-0 entries still flow (out_valid) but never write when the guard is on.
  assign out_reg_write = out_valid & out_entry.reg_write & ~(ZERO_GUARD & is_reg0);

  assign fwd_valid = out_reg_write;
  assign fwd_reg   = out_entry.write_reg;
  assign fwd_data  = out_entry.wb_data;

  // Flush does not clear the counter; it measures RF backpressure, not squashes.
  assign stall_cnt_d = (out_valid && !out_ready && stall_cnt_q != CNT_MAX)
                       ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
  assign stall_cnt   = stall_cnt_q;

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: queue-based model checked every posedge, plus
// directed literal expectations. Three builds share one stimulus: default,
// ZERO_GUARD=0 and CNT_W=4.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush, in_valid, in_mem_to_reg, in_reg_write, out_ready;
  logic [15:0] in_read_data, in_alu_result;
  logic [2:0]  in_write_reg;

  logic        in_ready, out_valid, out_reg_write, fwd_valid;
  logic [15:0] out_wb_data, fwd_data, stall_cnt;
  logic [2:0]  out_write_reg, fwd_reg;

  logic        ng_in_ready, ng_out_valid, ng_out_reg_write, ng_fwd_valid;
  logic [15:0] ng_out_wb_data, ng_fwd_data, ng_stall_cnt;
  logic [2:0]  ng_out_write_reg, ng_fwd_reg;

  logic        c4_in_ready, c4_out_valid, c4_out_reg_write, c4_fwd_valid;
  logic [15:0] c4_out_wb_data, c4_fwd_data;
  logic [3:0]  c4_stall_cnt;
  logic [2:0]  c4_out_write_reg, c4_fwd_reg;

  int checks = 0;
  int failures = 0;
  bit armed = 1'b0;

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_mem_to_reg(in_mem_to_reg), .in_read_data(in_read_data), .in_alu_result(in_alu_result),
    .in_write_reg(in_write_reg), .in_reg_write(in_reg_write), .out_valid(out_valid),
    .out_ready(out_ready), .out_wb_data(out_wb_data), .out_write_reg(out_write_reg),
    .out_reg_write(out_reg_write), .fwd_valid(fwd_valid), .fwd_reg(fwd_reg),
    .fwd_data(fwd_data), .stall_cnt(stall_cnt));

  mem_wb_stage #(.ZERO_GUARD(1'b0)) dut_ng (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ng_in_ready),
    .in_mem_to_reg(in_mem_to_reg), .in_read_data(in_read_data), .in_alu_result(in_alu_result),
    .in_write_reg(in_write_reg), .in_reg_write(in_reg_write), .out_valid(ng_out_valid),
    .out_ready(out_ready), .out_wb_data(ng_out_wb_data), .out_write_reg(ng_out_write_reg),
    .out_reg_write(ng_out_reg_write), .fwd_valid(ng_fwd_valid), .fwd_reg(ng_fwd_reg),
    .fwd_data(ng_fwd_data), .stall_cnt(ng_stall_cnt));

  mem_wb_stage #(.CNT_W(4)) dut_c4 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(c4_in_ready),
    .in_mem_to_reg(in_mem_to_reg), .in_read_data(in_read_data), .in_alu_result(in_alu_result),
    .in_write_reg(in_write_reg), .in_reg_write(in_reg_write), .out_valid(c4_out_valid),
    .out_ready(out_ready), .out_wb_data(c4_out_wb_data), .out_write_reg(c4_out_write_reg),
    .out_reg_write(c4_out_reg_write), .fwd_valid(c4_fwd_valid), .fwd_reg(c4_fwd_reg),
    .fwd_data(c4_fwd_data), .stall_cnt(c4_stall_cnt));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model: in-order queue of at most two entries ----------------
  typedef struct {
    logic [15:0] d;
    logic [2:0]  r;
    logic        w;
  } ent_t;

  ent_t m_q[$];
  int   m_cnt  = 0;
  int   m_cnt4 = 0;

  always @(negedge clk or posedge rst) begin : model
    bit   emit, acc;
    ent_t e;
    if (rst) begin
      m_q.delete();
      m_cnt  = 0;
      m_cnt4 = 0;
    end else begin
      emit = (m_q.size() > 0) && out_ready;
      acc  = in_valid && (m_q.size() < 2);
      if (m_q.size() > 0 && !out_ready) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt4 < 15) m_cnt4++;
      end
      if (flush) begin
        m_q.delete();
      end else begin
        if (emit) void'(m_q.pop_front());
        if (acc) begin
          e.d = in_mem_to_reg ? in_read_data : in_alu_result;
          e.r = in_write_reg;
          e.w = in_reg_write;
          m_q.push_back(e);
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(posedge clk) begin
    if (armed) begin
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_q.size() > 0});
      chk("in_ready", {31'd0, in_ready}, {31'd0, m_q.size() < 2});
      chk("stall_cnt", {16'd0, stall_cnt}, m_cnt);
      chk("c4_stall_cnt", {28'd0, c4_stall_cnt}, m_cnt4);
      if (m_q.size() > 0) begin
        chk("out_wb_data", {16'd0, out_wb_data}, {16'd0, m_q[0].d});
        chk("out_write_reg", {29'd0, out_write_reg}, {29'd0, m_q[0].r});
        chk("out_reg_write", {31'd0, out_reg_write}, {31'd0, m_q[0].w && m_q[0].r != 3'd0});
        chk("ng_out_reg_write", {31'd0, ng_out_reg_write}, {31'd0, m_q[0].w});
        chk("fwd_valid", {31'd0, fwd_valid}, {31'd0, m_q[0].w && m_q[0].r != 3'd0});
        chk("fwd_reg", {29'd0, fwd_reg}, {29'd0, m_q[0].r});
        chk("fwd_data", {16'd0, fwd_data}, {16'd0, m_q[0].d});
      end else begin
        chk("out_reg_write_idle", {31'd0, out_reg_write}, 32'd0);
        chk("fwd_valid_idle", {31'd0, fwd_valid}, 32'd0);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  // Advance across one negedge; returns at posedge+1 with outputs settled.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic m2r, input logic [15:0] rd, input logic [15:0] alu,
                      input logic [2:0] r, input logic rw);
    in_valid      = 1'b1;
    in_mem_to_reg = m2r;
    in_read_data  = rd;
    in_alu_result = alu;
    in_write_reg  = r;
    in_reg_write  = rw;
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    in_mem_to_reg = 1'b0;
    in_read_data = '0;
    in_alu_result = '0;
    in_write_reg = '0;
    in_reg_write = 1'b0;
    out_ready = 1'b0;
    cyc();
    cyc();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    armed = 1'b1;
    rst = 1'b0;

    // pass-through
    out_ready = 1'b1;
    push(1'b1, 16'hBEEF, 16'h0001, 3'd5, 1'b1);
    cyc();
    in_valid = 1'b0;
    chk("pt_data", {16'd0, out_wb_data}, 32'hBEEF);
    chk("pt_reg", {29'd0, out_write_reg}, 32'd5);
    chk("pt_rw", {31'd0, out_reg_write}, 32'd1);
    chk("pt_fwd", {31'd0, fwd_valid}, 32'd1);
    cyc();
    chk("pt_drained", {31'd0, out_valid}, 32'd0);

    // backpressure: A then B held, released in order
    out_ready = 1'b0;
    push(1'b0, 16'hFFFF, 16'h0011, 3'd1, 1'b1);
    cyc();
    push(1'b0, 16'hFFFF, 16'h0022, 3'd2, 1'b1);
    cyc();
    in_valid = 1'b0;
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_head_A", {16'd0, out_wb_data}, 32'h0011);
    chk("bp_cnt1", {16'd0, stall_cnt}, 32'd1);
    cyc();
    cyc();
    chk("bp_cnt3", {16'd0, stall_cnt}, 32'd3);
    out_ready = 1'b1;
    cyc();
    chk("bp_then_B", {16'd0, out_wb_data}, 32'h0022);
    chk("bp_B_reg", {29'd0, out_write_reg}, 32'd2);
    cyc();
    chk("bp_empty", {31'd0, out_valid}, 32'd0);
    chk("bp_cnt_hold", {16'd0, stall_cnt}, 32'd3);

    // flush with two held and a concurrent push
    out_ready = 1'b0;
    push(1'b0, 16'h0000, 16'h0033, 3'd3, 1'b1);
    cyc();
    push(1'b0, 16'h0000, 16'h0044, 3'd4, 1'b1);
    cyc();
    flush = 1'b1;
    push(1'b0, 16'h0000, 16'h0055, 3'd5, 1'b1);
    cyc();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_out_valid", {31'd0, out_valid}, 32'd0);
    chk("fl_in_ready", {31'd0, in_ready}, 32'd1);
    chk("fl_cnt_kept", {16'd0, stall_cnt}, 32'd5);

    // zero guard, then back-to-back emit&accept with reg_write=0
    out_ready = 1'b1;
    push(1'b0, 16'h0000, 16'h0066, 3'd0, 1'b1);
    cyc();
    push(1'b1, 16'h0077, 16'h1234, 3'd6, 1'b0);
    chk("zg_valid", {31'd0, out_valid}, 32'd1);
    chk("zg_rw", {31'd0, out_reg_write}, 32'd0);
    chk("zg_ng_rw", {31'd0, ng_out_reg_write}, 32'd1);
    cyc();
    in_valid = 1'b0;
    chk("rw0_data", {16'd0, out_wb_data}, 32'h0077);
    chk("rw0_rw", {31'd0, out_reg_write}, 32'd0);
    cyc();
    chk("rw0_drained", {31'd0, out_valid}, 32'd0);

    // saturation on the CNT_W=4 build
    out_ready = 1'b0;
    push(1'b0, 16'h0000, 16'h0088, 3'd7, 1'b1);
    cyc();
    in_valid = 1'b0;
    repeat (20) cyc();
    chk("sat_c4", {28'd0, c4_stall_cnt}, 32'd15);
    chk("sat_main", {16'd0, stall_cnt}, 32'd25);

    // reset mid-stream with two entries held
    push(1'b0, 16'h0000, 16'h0099, 3'd1, 1'b1);
    cyc();
    in_valid = 1'b0;
    chk("pre_rst_full", {31'd0, in_ready}, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("mrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mrst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("mrst_c4_cnt", {28'd0, c4_stall_cnt}, 32'd0);
    cyc();
    rst = 1'b0;
    out_ready = 1'b1;
    cyc();
    chk("post_rst_no_write", {31'd0, out_reg_write}, 32'd0);
    chk("post_rst_idle", {31'd0, out_valid}, 32'd0);

    armed = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
